// File: rtl/audio_level_meter.sv
// Per-channel windowed peak meter with log2 bar levels, instant attack and one-step decay per window.
// Optional clip indicators are built when LEVEL_METER_CLIP_EN is defined.
module audio_level_meter #(
    parameter int DATA_W      = 16,
    parameter int WINDOW_LOG2 = 10,
    parameter int LEVEL_W     = 4
) (
    input  logic               AUD_BCLK,
    input  logic               Reset,
    input  logic               sample_valid,
    input  logic [DATA_W-1:0]  left_sample,
    input  logic [DATA_W-1:0]  right_sample,
    output logic [LEVEL_W-1:0] left_level,
    output logic [LEVEL_W-1:0] right_level,
    output logic               level_valid,
    output logic               left_clip,
    output logic               right_clip
);

    localparam logic [DATA_W-2:0] MAG_MAX = '1;

    // Magnitude in DATA_W-1 bits; the most negative code saturates instead of wrapping to 0.
    function automatic logic [DATA_W-2:0] sat_mag(input logic signed [DATA_W-1:0] s);
        logic signed [DATA_W-1:0] neg;
        neg = -s;
        if (!s[DATA_W-1]) begin
            return s[DATA_W-2:0];
        end else if (neg[DATA_W-1]) begin
            return MAG_MAX;
        end else begin
            return neg[DATA_W-2:0];
        end
    endfunction

    function automatic logic [DATA_W-2:0] peak_max(input logic [DATA_W-2:0] a,
                                                    input logic [DATA_W-2:0] b);
        return (a > b) ? a : b;
    endfunction

    // Level = index of the highest set bit plus one, 0 for a silent window.
    function automatic logic [LEVEL_W-1:0] log2_level(input logic [DATA_W-2:0] p);
        logic [LEVEL_W-1:0] l;
        l = '0;
        for (int i = 0; i < DATA_W - 1; i++) begin
            if (p[i]) begin
                l = LEVEL_W'(i + 1);
            end
        end
        return l;
    endfunction

    function automatic logic [LEVEL_W-1:0] decay_level(input logic [LEVEL_W-1:0] lvl,
                                                        input logic [LEVEL_W-1:0] cur);
        logic [LEVEL_W-1:0] dec;
        dec = (cur == '0) ? '0 : cur - LEVEL_W'(1);
        return (lvl > dec) ? lvl : dec;
    endfunction

    logic signed [DATA_W-1:0] left_s_p0;
    logic signed [DATA_W-1:0] right_s_p0;
    logic [DATA_W-2:0]        left_mag_p0;
    logic [DATA_W-2:0]        right_mag_p0;
    logic [DATA_W-2:0]        left_peak_p0;
    logic [DATA_W-2:0]        right_peak_p0;
    logic [LEVEL_W-1:0]       left_lvl_p0;
    logic [LEVEL_W-1:0]       right_lvl_p0;
    logic                     last_p0;

    logic [WINDOW_LOG2-1:0]   frame_cnt;
    logic [DATA_W-2:0]        left_acc;
    logic [DATA_W-2:0]        right_acc;
    logic [LEVEL_W-1:0]       left_level_p1;
    logic [LEVEL_W-1:0]       right_level_p1;
    logic                     vld_p1;

    // Stage p0: magnitude, window peak (including the current sample) and its level.
    always_comb begin
        left_s_p0     = left_sample;
        right_s_p0    = right_sample;
        left_mag_p0   = sat_mag(left_s_p0);
        right_mag_p0  = sat_mag(right_s_p0);
        left_peak_p0  = peak_max(left_acc, left_mag_p0);
        right_peak_p0 = peak_max(right_acc, right_mag_p0);
        left_lvl_p0   = log2_level(left_peak_p0);
        right_lvl_p0  = log2_level(right_peak_p0);
        last_p0       = &frame_cnt;
    end

    // Stage p1: accumulators, frame counter and the registered display levels.
    always_ff @(posedge AUD_BCLK or posedge Reset) begin
        if (Reset) begin
            frame_cnt      <= '0;
            left_acc       <= '0;
            right_acc      <= '0;
            left_level_p1  <= '0;
            right_level_p1 <= '0;
            vld_p1         <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            if (sample_valid) begin
                frame_cnt <= frame_cnt + WINDOW_LOG2'(1);
                if (last_p0) begin
                    left_acc       <= '0;
                    right_acc      <= '0;
                    left_level_p1  <= decay_level(left_lvl_p0, left_level_p1);
                    right_level_p1 <= decay_level(right_lvl_p0, right_level_p1);
                    vld_p1         <= 1'b1;
                end else begin
                    left_acc  <= left_peak_p0;
                    right_acc <= right_peak_p0;
                end
            end
        end
    end

    assign left_level  = left_level_p1;
    assign right_level = right_level_p1;
    assign level_valid = vld_p1;

`ifdef LEVEL_METER_CLIP_EN
    logic left_hit_p0;
    logic right_hit_p0;
    logic left_sticky;
    logic right_sticky;
    logic left_clip_p1;
    logic right_clip_p1;

    assign left_hit_p0  = (left_mag_p0 == MAG_MAX);
    assign right_hit_p0 = (right_mag_p0 == MAG_MAX);

    // Sticky bits collect the current window; the flags publish it with the level update.
    always_ff @(posedge AUD_BCLK or posedge Reset) begin
        if (Reset) begin
            left_sticky   <= 1'b0;
            right_sticky  <= 1'b0;
            left_clip_p1  <= 1'b0;
            right_clip_p1 <= 1'b0;
        end else if (sample_valid) begin
            if (last_p0) begin
                left_clip_p1  <= left_sticky | left_hit_p0;
                right_clip_p1 <= right_sticky | right_hit_p0;
                left_sticky   <= 1'b0;
                right_sticky  <= 1'b0;
            end else begin
                left_sticky  <= left_sticky | left_hit_p0;
                right_sticky <= right_sticky | right_hit_p0;
            end
        end
    end

    assign left_clip  = left_clip_p1;
    assign right_clip = right_clip_p1;
`else
    assign left_clip  = 1'b0;
    assign right_clip = 1'b0;
`endif

endmodule

// File: tb/tb_audio_level_meter.sv
// Directed test of audio_level_meter with a 4-frame window and hand-computed levels.
module tb_audio_level_meter;

`ifdef LEVEL_METER_CLIP_EN
    localparam int CLIP = 1;
`else
    localparam int CLIP = 0;
`endif

    logic        AUD_BCLK;
    logic        Reset;
    logic        sample_valid;
    logic [15:0] left_sample;
    logic [15:0] right_sample;
    logic [3:0]  left_level;
    logic [3:0]  right_level;
    logic        level_valid;
    logic        left_clip;
    logic        right_clip;

    int n_cmp = 0;
    int n_bad = 0;

    audio_level_meter #(.DATA_W(16), .WINDOW_LOG2(2), .LEVEL_W(4)) dut (
        .AUD_BCLK     (AUD_BCLK),
        .Reset        (Reset),
        .sample_valid (sample_valid),
        .left_sample  (left_sample),
        .right_sample (right_sample),
        .left_level   (left_level),
        .right_level  (right_level),
        .level_valid  (level_valid),
        .left_clip    (left_clip),
        .right_clip   (right_clip)
    );

    initial begin
        AUD_BCLK = 1'b0;
        forever #5 AUD_BCLK = ~AUD_BCLK;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".lvl_l"}, int'(left_level), 0);
        chk({tag, ".lvl_r"}, int'(right_level), 0);
        chk({tag, ".vld"}, int'(level_valid), 0);
        chk({tag, ".clip_l"}, int'(left_clip), 0);
        chk({tag, ".clip_r"}, int'(right_clip), 0);
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the strobed edge.
    task automatic strobe(input int l, input int r);
        left_sample  = 16'(l);
        right_sample = 16'(r);
        sample_valid = 1'b1;
        @(posedge AUD_BCLK);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge AUD_BCLK);
            #1;
        end
    endtask

    task automatic run_window(input string tag, input int l[4], input int r[4], input int g[4],
                              input int el, input int er, input int ecl, input int ecr);
        for (int i = 0; i < 4; i++) begin
            strobe(l[i], r[i]);
            if (i < 3) begin
                chk({tag, ".early_vld"}, int'(level_valid), 0);
            end else begin
                chk({tag, ".vld"}, int'(level_valid), 1);
                chk({tag, ".lvl_l"}, int'(left_level), el);
                chk({tag, ".lvl_r"}, int'(right_level), er);
                chk({tag, ".clip_l"}, int'(left_clip), ecl);
                chk({tag, ".clip_r"}, int'(right_clip), ecr);
            end
            idle(g[i]);
        end
    endtask

    initial begin
        Reset        = 1'b1;
        sample_valid = 1'b0;
        left_sample  = '0;
        right_sample = '0;
        #12;
        chk_all_zero("reset");
        Reset = 1'b0;
        @(posedge AUD_BCLK);
        #1;

        // Basic window: peak |-300| gives level 9, silent right stays 0.
        run_window("win1", '{100, -300, 50, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, 9, 0, 0, 0);
        idle(1);
        chk("win1.vld_drop", int'(level_valid), 0);
        idle(4);
        chk("win1.hold_l", int'(left_level), 9);

        // Silent windows decay one step each and floor at 0.
        for (int k = 8; k >= -1; k--) begin
            run_window("decay", '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0},
                       (k < 0) ? 0 : k, 0, 0, 0);
        end
        run_window("peak1", '{0, 1, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, 1, 0, 0, 0);

        // Full-scale on both channels, then a quiet window.
        run_window("clip", '{0, -32768, 0, 0}, '{0, 0, 32767, 0}, '{0, 0, 0, 0}, 15, 15, CLIP, CLIP);
        run_window("after_clip", '{5, 0, -2, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, 14, 14, 0, 0);

        // Asynchronous reset between edges clears outputs at once.
        #3;
        Reset = 1'b1;
        #1;
        chk_all_zero("async_rst");
        strobe(20000, 20000);
        #3;
        Reset = 1'b0;
        idle(1);
        chk_all_zero("rst_strobe_ignored");

        // Irregular gaps and back-to-back strobes.
        run_window("gaps1", '{100, -300, 50, 0}, '{0, -7, 2, 0}, '{3, 0, 7, 1}, 9, 3, 0, 0);
        run_window("gaps2", '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 5}, 8, 2, 0, 0);

        // Reset partway through a loud window discards it.
        strobe(1000, 0);
        idle(2);
        strobe(-1000, 0);
        #3;
        Reset = 1'b1;
        #2;
        Reset = 1'b0;
        idle(1);
        chk("midrst.lvl_l", int'(left_level), 0);
        run_window("post_rst", '{3, -3, 2, 1}, '{0, 0, 0, 0}, '{1, 0, 2, 0}, 2, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/audio_level_meter.md
Name: audio_level_meter

Overview:
Downstream consumer of the audio ADC deserializer. Takes completed signed left/right sample pairs and measures the per-channel peak magnitude over a fixed window of frames. Converts each peak to a log2 (≈6 dB/step) bar level with instant attack and one-step-per-window decay. The levels feed the visualizer's bar renderer.

Parameters:
DATA_W, 16, sample width in bits (signed two's complement)
WINDOW_LOG2, 10, window length = 2**WINDOW_LOG2 valid frames
LEVEL_W, 4, level output width; must satisfy 2**LEVEL_W >= DATA_W (levels 0..DATA_W-1)

Ports:
AUD_BCLK  input  1  audio bit clock; all logic on rising edge
Reset  input  1  asynchronous, active-high reset
sample_valid  input  1  one-cycle strobe: left_sample/right_sample hold a new frame
left_sample  input  DATA_W  signed left-channel sample
right_sample  input  DATA_W  signed right-channel sample
left_level  output  LEVEL_W  displayed left bar level, 0..DATA_W-1
right_level  output  LEVEL_W  displayed right bar level
level_valid  output  1  one-cycle pulse: levels just updated
left_clip  output  1  left clip indicator (Optional Feature)
right_clip  output  1  right clip indicator (Optional Feature)

Behaviour:
- Clock is AUD_BCLK only. Reset is asynchronous and active-high. Reset clears the frame counter, both peak accumulators, both levels, level_valid and both clip flags to 0.
- Inputs are sampled only on cycles with sample_valid=1. Idle cycles change no state apart from level_valid returning to 0.
- Magnitude: mag = (s<0) ? -s : s, computed in DATA_W-1 bits. The most negative value saturates to 2**(DATA_W-1)-1; it never wraps to 0.
- Frame counter: WINDOW_LOG2 bits, increments on each sample_valid and wraps from all-ones to 0. The frame on which the counter is all-ones is the last frame of the window.
- Peak accumulator, per channel, on sample_valid:
  - non-last frame: acc <= max(acc, mag)
  - last frame: window peak = max(acc, mag), which includes the current sample; acc <= 0
- Level mapping: lvl = 0 if peak==0, else floor(log2(peak))+1. Examples: 1→1, 300→9, 32767→15.
- Display update on the last frame, per channel: level <= max(lvl, level-1), with level-1 floored at 0. The new value is visible and level_valid=1 on the cycle after the sample_valid edge (latency 1). Both are registered.
- level_valid is high for exactly one cycle per window. Levels hold their value between updates.
- The window peak, level computation and display update complete in the same edge. There is no pipeline hazard, even with back-to-back sample_valid on consecutive cycles.
- Reset mid-window discards the partial window. The next level_valid requires a full 2**WINDOW_LOG2 valid frames after reset is released.
- sample_valid asserted while Reset is high is ignored.

Optional Feature:
Macro LEVEL_METER_CLIP_EN.
- Defined: per channel, a sticky bit is set on any frame in the current window with mag == 2**(DATA_W-1)-1.
  - At the window-end update, x_clip <= sticky bit, including the last frame; the sticky bit then clears.
  - x_clip therefore reports the previous window and is updated together with the level.
- Undefined: left_clip and right_clip are tied to 0 and no clip logic is present.

Test Plan:
1. Assert Reset asynchronously mid-cycle → all outputs 0 immediately, without waiting for a clock edge.
2. WINDOW_LOG2=2, left = 100,-300,50,0, right = 0 ×4 → one cycle after the 4th strobe: level_valid=1, left_level=9, right_level=0. level_valid=0 on the following cycle.
3. Continue from 2 with all-zero windows → left_level 8,7,...,0 on successive windows, then stays 0. A window with peak 1 after reaching 0 gives 1.
4. Left=-32768 in a window (CLIP_EN defined) → left_level=15, left_clip=1 for that update. Next window with peak 5 → left_level=14, left_clip=0. With CLIP_EN undefined, clip stays 0.
5. Gaps: strobes with 0–7 idle cycles between them, plus back-to-back strobes → update occurs exactly after every 4th strobe, with values identical to the gap-free run.
6. Reset after 2 frames of a window with peak 1000, then 4 frames of peak 3 → first level_valid comes after the 4th post-reset strobe with left_level=2, and no trace of the 1000.
